// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive-side buffer.
// The receiver uses the same byte width, synchroniser depth and idle levels.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned UART_SYNC_STAGES = 2;
    localparam int unsigned FIFO_DEPTH       = 16;

    // Idle levels of the receiver handshake lines.
    localparam logic RX_COMPLETE_IDLE = 1'b1;
    localparam logic RX_ERROR_IDLE    = 1'b0;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_sync_ff.sv
// Single-bit synchroniser chain for asynchronous control inputs.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous reset, active low; every stage resets to RST_VAL
//   d     - asynchronous input
//   q     - synchronised output (last stage)
module uart_sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the input in at bit 0; the output is the oldest stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : uart_sync_ff

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: brings each completed byte
// into the system clock domain and stores it in a first-word-fall-through
// FIFO, with sticky framing-error and overflow flags.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   rx_data      - byte from the receiver (stable bus, qualified by the strobe)
//   rx_complete  - active-low byte strobe; falling edge marks a new byte
//   rx_error     - receiver error level
//   rd_en        - pop the head entry (ignored while empty)
//   err_clr      - clear err_flag and overflow
//   rd_data      - head entry, valid while empty=0
//   empty, full, count - FIFO occupancy
//   err_flag     - sticky, set on a synchronised rising edge of rx_error
//   overflow     - sticky, set when a byte is dropped because the FIFO is full
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DATA_W      = UART_DATA_W,
    parameter int unsigned DEPTH       = FIFO_DEPTH,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_complete,
    input  logic              rx_error,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              err_flag,
    output logic              overflow
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic cpl_sync;
    logic err_sync;

    uart_sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RX_COMPLETE_IDLE)
    ) u_sync_cpl (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_complete),
        .q     (cpl_sync)
    );

    uart_sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (RX_ERROR_IDLE)
    ) u_sync_err (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_error),
        .q     (err_sync)
    );

    logic              cpl_prev_q, cpl_prev_d;
    logic              err_prev_q, err_prev_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic              push_q, push_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_flag_q, err_flag_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic fall_det;
    logic rise_det;
    logic empty_c;
    logic full_c;
    logic do_push;
    logic do_pop;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

    // Edge detection, capture, pointer/count and sticky flag next-state.
    always_comb begin
        cpl_prev_d = cpl_sync;
        err_prev_d = err_sync;
        cap_data_d = cap_data_q;
        push_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_flag_d = err_flag_q;
        overflow_d = overflow_q;

        fall_det = cpl_prev_q & ~cpl_sync;
        rise_det = ~err_prev_q & err_sync;

        // rx_data is held stable by the receiver, so it is sampled directly.
        if (fall_det) begin
            cap_data_d = rx_data;
            push_d     = 1'b1;
        end

        do_pop  = rd_en & ~empty_c;
        // A pop frees the slot in the same cycle, so push-while-full is legal with rd_en.
        do_push = push_q & (~full_c | do_pop);

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end

        // Set events take priority over a simultaneous clear.
        if (err_clr) begin
            err_flag_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (rise_det) begin
            err_flag_d = 1'b1;
        end
        if (push_q && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_prev_q <= RX_COMPLETE_IDLE;
            err_prev_q <= RX_ERROR_IDLE;
            cap_data_q <= '0;
            push_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_flag_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cpl_prev_q <= cpl_prev_d;
            err_prev_q <= err_prev_d;
            cap_data_q <= cap_data_d;
            push_q     <= push_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_flag_q <= err_flag_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage has no reset; contents are only visible through count-qualified reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= cap_data_q;
        end
    end

    // FWFT head; forced to zero while empty so reset shows a clean bus.
    assign rd_data  = empty_c ? '0 : mem_q[rd_ptr_q];
    assign empty    = empty_c;
    assign full     = full_c;
    assign count    = count_q;
    assign err_flag = err_flag_q;
    assign overflow = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue-based model of the byte stream plus
// sticky flags, driven by directed scenarios and a randomised mix.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       rx_error;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       err_flag;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_m[$];
    bit         ovf_m;
    bit         err_m;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_complete (rx_complete),
        .rx_error    (rx_error),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .err_flag    (err_flag),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // One byte through the receiver handshake; optionally pop in the write cycle.
    task automatic send_byte(input logic [7:0] b, input bit pop);
        int sz;
        @(negedge clk);
        rx_data     = b;
        rx_complete = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_en = pop;
        sz = q_m.size();
        if (pop && sz != 0) begin
            checks++;
            if (rd_data !== q_m[0]) begin
                errors++;
                $display("FAIL send_pop_head: got %h expected %h", rd_data, q_m[0]);
            end
            void'(q_m.pop_front());
        end
        if (q_m.size() < DEPTH) q_m.push_back(b);
        else ovf_m = 1'b1;
        @(negedge clk);
        rd_en       = 1'b0;
        rx_complete = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_byte();
        @(negedge clk);
        if (q_m.size() != 0) begin
            checks++;
            if (empty !== 1'b0 || rd_data !== q_m[0]) begin
                errors++;
                $display("FAIL pop_head: got %h empty=%b expected %h", rd_data, empty, q_m[0]);
            end
            void'(q_m.pop_front());
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_data = '0; rx_complete = 1'b1; rx_error = 1'b0;
        rd_en = 1'b0; err_clr = 1'b0;
        q_m.delete(); ovf_m = 1'b0; err_m = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({empty, full, count, err_flag, overflow} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_flags: got e%b f%b c%0d err%b ovf%b expected e1 f0 c0 err0 ovf0",
                     empty, full, count, err_flag, overflow);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
    endtask

    task automatic test_single_byte();
        int n;
        @(negedge clk);
        rx_data = 8'hA5;
        rx_complete = 1'b0;
        n = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n = i;
            if (!empty) break;
        end
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: empty=%b after %0d clk expected 0 within 4", empty, n);
        end
        @(negedge clk);
        rx_complete = 1'b1;
        q_m.push_back(8'hA5);
        repeat (3) @(negedge clk);
        checks++;
        if (rd_data !== 8'hA5 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_data: got %h cnt %0d expected a5 cnt 1", rd_data, count);
        end
        pop_byte();
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_drain: got empty=%b cnt %0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL fill_full: got full=%b cnt %0d expected 1 16", full, count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rd_data !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_pop_order: got %h expected %h", rd_data, 8'(i));
            end
            pop_byte();
        end
        for (int i = 16; i < 24; i++) send_byte(8'(i), 1'b0);
        for (int i = 8; i < 24; i++) begin
            checks++;
            if (rd_data !== 8'(i)) begin
                errors++;
                $display("FAIL wrap_drain_order: got %h expected %h", rd_data, 8'(i));
            end
            pop_byte();
        end
        checks++;
        if (empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL wrap_empty: got empty=%b cnt %0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] head;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        head = q_m[0];
        send_byte(8'hFF, 1'b0);
        checks++;
        if (overflow !== 1'b1 || overflow !== ovf_m || count !== 5'd16 || rd_data !== head) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b cnt %0d head %h expected 1 16 %h",
                     overflow, count, rd_data, head);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        ovf_m = 1'b0;
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_clr: got ovf=%b cnt %0d expected 0 16", overflow, count);
        end
    endtask

    task automatic test_push_pop_full();
        send_byte(8'h3C, 1'b1);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL pushpop_full: got cnt %0d ovf=%b expected 16 0", count, overflow);
        end
        checks++;
        if (q_m[$] !== 8'h3C) begin
            errors++;
            $display("FAIL pushpop_model_tail: got %h expected 3c", q_m[$]);
        end
        while (q_m.size() > 1) pop_byte();
        checks++;
        if (rd_data !== 8'h3C || count !== 5'd1) begin
            errors++;
            $display("FAIL pushpop_last: got %h cnt %0d expected 3c 1", rd_data, count);
        end
        pop_byte();
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1, 2: send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                3: pop_byte();
                default: begin
                    @(negedge clk); err_clr = 1'b1;
                    @(negedge clk); err_clr = 1'b0;
                    ovf_m = 1'b0; err_m = 1'b0;
                end
            endcase
            checks++;
            if (count !== 5'(q_m.size()) || overflow !== ovf_m || err_flag !== err_m ||
                empty !== (q_m.size() == 0) || full !== (q_m.size() == DEPTH)) begin
                errors++;
                $display("FAIL random_state it%0d: got cnt %0d ovf=%b err=%b e%b f%b expected cnt %0d ovf=%b err=%b",
                         it, count, overflow, err_flag, empty, full, q_m.size(), ovf_m, err_m);
            end
        end
        while (q_m.size() > 0) pop_byte();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        ovf_m = 1'b0;
    endtask

    task automatic test_error_reset();
        int n;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        @(negedge clk);
        rx_error = 1'b1;
        n = 0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            n = i;
            if (err_flag) break;
        end
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL error_set: err_flag=%b after %0d clk expected 1 within 3", err_flag, n);
        end
        checks++;
        if (count !== 5'd5) begin
            errors++;
            $display("FAIL error_count: got %0d expected 5", count);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1 || err_flag !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL reset_midop: got empty=%b err=%b cnt %0d expected 1 0 0",
                     empty, err_flag, count);
        end
        rx_error = 1'b0;
        q_m.delete(); ovf_m = 1'b0; err_m = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (empty !== 1'b1 || err_flag !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: got empty=%b err=%b ovf=%b expected 1 0 0",
                     empty, err_flag, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_wrap();
        test_overflow();
        test_push_pop_full();
        test_random();
        test_error_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_fifo
